pe_stream_responder: RTL and testbench

- Top-level responder to the PE controller's stream-request interface.
- Accepts a filter-stream and/or input-stream request, reads words from the on-chip data buffer, and streams them to the PE over a valid/ready channel.
- Holds the filter-finish and input-finish flags high until the request is withdrawn, so the PE can wait on both at once.

---
 rtl/pe_stream_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_pe_stream_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_responder.sv
// pe_stream_responder: answers PE filter/input stream requests by reading the
// on-chip data buffer and streaming words over a valid/ready channel.
// Sequence per request: IDLE -> FILT (optional) -> INP (optional) -> DONE -> IDLE.
// A 2-entry skid FIFO absorbs the 1-cycle buffer read latency so the stream
// sustains one beat per cycle while the PE is ready.
// Optional macro STREAM_RESP_PERF_CNT_EN adds saturating stall/beat counters.
module pe_stream_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int K_W     = 6,
  parameter int LAYER_W = 3,
  parameter int LEN_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_filter_valid,
  input  logic [K_W-1:0]     req_filter_k,
  input  logic [LAYER_W-1:0] req_conv_layer,
  input  logic               req_input_valid,
  input  logic [ADDR_W-1:0]  cfg_filter_base,
  input  logic [LEN_W-1:0]   cfg_filter_words,
  input  logic [ADDR_W-1:0]  cfg_input_base,
  input  logic [LEN_W-1:0]   cfg_input_words,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               strm_valid,
  input  logic               strm_ready,
  output logic [DATA_W-1:0]  strm_data,
  output logic               strm_is_filter,
  output logic               strm_last,
  output logic [LAYER_W-1:0] strm_layer,
  output logic               stream_filter_finish,
  output logic               stream_input_finish,
  output logic               busy
`ifdef STREAM_RESP_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_beats
`endif
);

  typedef enum logic [1:0] {IDLE, FILT, INP, DONE} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              is_filt;
    logic              last;
  } beat_t;

  state_e              state_q, state_d;
  logic                lat_inp_q, lat_inp_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [ADDR_W-1:0]   inp_base_q, inp_base_d;
  logic [LEN_W-1:0]    inp_words_q, inp_words_d;
  logic [ADDR_W-1:0]   seg_addr_q, seg_addr_d;
  logic [LEN_W-1:0]    rd_left_q, rd_left_d;
  logic [LEN_W-1:0]    beat_left_q, beat_left_d;
  logic                fin_f_q, fin_f_d;
  logic                fin_i_q, fin_i_d;

  // one read may be in flight; its tags ride alongside until the data returns
  logic                infl_q, infl_filt_q, infl_last_q;

  beat_t               fifo_q [2];
  logic                wptr_q, rptr_q;
  logic [1:0]          cnt_q;
  beat_t               head;

  logic                seg_act, issue, xfer, seg_done;
  logic [1:0]          occ;
  logic [ADDR_W-1:0]   k_off, filt_addr;

  // k*words wraps mod 2^ADDR_W, so operands are sized to the address width
  assign k_off     = ADDR_W'(req_filter_k) * ADDR_W'(cfg_filter_words);
  assign filt_addr = cfg_filter_base + k_off;

  assign head       = fifo_q[rptr_q];
  assign strm_valid = (cnt_q != 2'd0);
  assign xfer       = strm_valid & strm_ready;
  assign seg_act    = (state_q == FILT) || (state_q == INP);

  // occupancy after this cycle's pop, counting the returning read; the pop
  // credit is what lets a new read issue every cycle under full throughput
  assign occ      = cnt_q + {1'b0, infl_q} - {1'b0, xfer};
  assign issue    = seg_act && (rd_left_q != '0) && (occ < 2'd2);
  assign seg_done = (beat_left_q == '0) || ((beat_left_q == LEN_W'(1)) && xfer);

  assign mem_rd_en            = issue;
  assign mem_rd_addr          = seg_addr_q;
  assign strm_data            = head.data;
  assign strm_is_filter       = strm_valid & head.is_filt;
  assign strm_last            = strm_valid & head.last;
  assign strm_layer           = layer_q;
  assign stream_filter_finish = fin_f_q;
  assign stream_input_finish  = fin_i_q;
  assign busy                 = (state_q != IDLE);

  // next-state: request latch, segment counters and sticky finish flags
  always_comb begin
    state_d     = state_q;
    lat_inp_d   = lat_inp_q;
    layer_d     = layer_q;
    inp_base_d  = inp_base_q;
    inp_words_d = inp_words_q;
    seg_addr_d  = seg_addr_q;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q;
    fin_f_d     = fin_f_q;
    fin_i_d     = fin_i_q;
    case (state_q)
      IDLE: begin
        if (req_filter_valid || req_input_valid) begin
          lat_inp_d   = req_input_valid;
          layer_d     = req_conv_layer;
          inp_base_d  = cfg_input_base;
          inp_words_d = cfg_input_words;
          if (req_filter_valid) begin
            state_d     = FILT;
            seg_addr_d  = filt_addr;
            rd_left_d   = cfg_filter_words;
            beat_left_d = cfg_filter_words;
          end else begin
            state_d     = INP;
            seg_addr_d  = cfg_input_base;
            rd_left_d   = cfg_input_words;
            beat_left_d = cfg_input_words;
          end
        end
      end
      FILT, INP: begin
        if (issue) begin
          seg_addr_d = seg_addr_q + 1'b1;
          rd_left_d  = rd_left_q - 1'b1;
        end
        if (xfer) beat_left_d = beat_left_q - 1'b1;
        // segment ends when its last beat leaves, so input reads never
        // overlap filter data in the FIFO
        if (seg_done) begin
          if (state_q == FILT) begin
            fin_f_d = 1'b1;
            if (lat_inp_q) begin
              state_d     = INP;
              seg_addr_d  = inp_base_q;
              rd_left_d   = inp_words_q;
              beat_left_d = inp_words_q;
            end else begin
              state_d = DONE;
            end
          end else begin
            fin_i_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!req_filter_valid && !req_input_valid) begin
          fin_f_d = 1'b0;
          fin_i_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_inp_q   <= 1'b0;
      layer_q     <= '0;
      inp_base_q  <= '0;
      inp_words_q <= '0;
      seg_addr_q  <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      fin_f_q     <= 1'b0;
      fin_i_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_inp_q   <= lat_inp_d;
      layer_q     <= layer_d;
      inp_base_q  <= inp_base_d;
      inp_words_q <= inp_words_d;
      seg_addr_q  <= seg_addr_d;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      fin_f_q     <= fin_f_d;
      fin_i_q     <= fin_i_d;
    end
  end

  // in-flight read tracking and skid FIFO push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_q      <= 1'b0;
      infl_filt_q <= 1'b0;
      infl_last_q <= 1'b0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      infl_q      <= issue;
      infl_filt_q <= (state_q == FILT);
      infl_last_q <= (rd_left_q == LEN_W'(1));
      if (infl_q) begin
        fifo_q[wptr_q] <= '{data: mem_rd_data, is_filt: infl_filt_q, last: infl_last_q};
        wptr_q         <= ~wptr_q;
      end
      if (xfer) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, xfer};
    end
  end

`ifdef STREAM_RESP_PERF_CNT_EN
  // saturating stall and beat counters, cleared by reset only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_beats        <= '0;
    end else begin
      if (strm_valid && !strm_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (xfer && (perf_beats != '1))
        perf_beats <= perf_beats + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_stream_responder.sv
// Self-checking bench for pe_stream_responder: a buffer model with 1-cycle
// read latency, a negedge monitor, and an expected beat/address list built
// directly from the request (base + k*words, wrapping, filter then input).
module tb_pe_stream_responder;
  localparam int DATA_W = 32, ADDR_W = 12, K_W = 6, LAYER_W = 3, LEN_W = 10;

  logic               clk, rst;
  logic               req_filter_valid, req_input_valid;
  logic [K_W-1:0]     req_filter_k;
  logic [LAYER_W-1:0] req_conv_layer;
  logic [ADDR_W-1:0]  cfg_filter_base, cfg_input_base;
  logic [LEN_W-1:0]   cfg_filter_words, cfg_input_words;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [DATA_W-1:0]  mem_rd_data;
  logic               strm_valid, strm_ready, strm_is_filter, strm_last;
  logic [DATA_W-1:0]  strm_data;
  logic [LAYER_W-1:0] strm_layer;
  logic               stream_filter_finish, stream_input_finish, busy;

  pe_stream_responder dut (
    .clk(clk), .rst(rst),
    .req_filter_valid(req_filter_valid), .req_filter_k(req_filter_k),
    .req_conv_layer(req_conv_layer), .req_input_valid(req_input_valid),
    .cfg_filter_base(cfg_filter_base), .cfg_filter_words(cfg_filter_words),
    .cfg_input_base(cfg_input_base), .cfg_input_words(cfg_input_words),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_data(strm_data),
    .strm_is_filter(strm_is_filter), .strm_last(strm_last), .strm_layer(strm_layer),
    .stream_filter_finish(stream_filter_finish),
    .stream_input_finish(stream_input_finish), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer model: data one cycle after the strobe, garbage otherwise
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom;

  typedef struct packed { logic [DATA_W-1:0] data; logic isf; logic last; } tb_beat_t;
  tb_beat_t          exp_q[$], got_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$], got_addr_q[$];
  int  issued, xferd, max_out, stab_err, checks, errors;
  bit  prev_stall;
  tb_beat_t prev_beat;
  bit  cur_fv, cur_iv;
  logic [LAYER_W-1:0] cur_layer;

  logic [53:0] outs;
  assign outs = {mem_rd_en, mem_rd_addr, strm_valid, strm_data, strm_is_filter, strm_last,
                 strm_layer, stream_filter_finish, stream_input_finish, busy};

  // monitor: record issued addresses and transferred beats, watch stall stability
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall && (!strm_valid || {strm_data, strm_is_filter, strm_last} !== prev_beat))
        stab_err++;
      prev_stall = strm_valid && !strm_ready;
      prev_beat  = '{strm_data, strm_is_filter, strm_last};
      if (mem_rd_en) begin got_addr_q.push_back(mem_rd_addr); issued++; end
      if (strm_valid && strm_ready) begin
        got_q.push_back('{strm_data, strm_is_filter, strm_last});
        xferd++;
      end
      if (issued - xferd > max_out) max_out = issued - xferd;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic int first_bad_beat();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return (got_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic int first_bad_addr();
    int n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) if (got_addr_q[i] !== exp_addr_q[i]) return i;
    return (got_addr_q.size() == exp_addr_q.size()) ? -1 : n;
  endfunction

  // present a request (call at posedge+1 with the DUT idle) and build the
  // expected reads/beats from the request rules
  task automatic drive_req(input bit fv, input int k, input int layer, input bit iv,
                           input int fb, input int fw, input int ib, input int iw);
    int a;
    exp_q.delete(); got_q.delete(); exp_addr_q.delete(); got_addr_q.delete();
    issued = 0; xferd = 0; max_out = 0; stab_err = 0;
    cur_fv = fv; cur_iv = iv; cur_layer = LAYER_W'(layer);
    req_filter_valid = fv; req_input_valid = iv;
    req_filter_k = K_W'(k); req_conv_layer = LAYER_W'(layer);
    cfg_filter_base = ADDR_W'(fb); cfg_filter_words = LEN_W'(fw);
    cfg_input_base = ADDR_W'(ib); cfg_input_words = LEN_W'(iw);
    if (fv) begin
      a = (fb + k * fw) % 4096;
      for (int i = 0; i < fw; i++) begin
        exp_addr_q.push_back(ADDR_W'((a + i) % 4096));
        exp_q.push_back('{mem[(a + i) % 4096], 1'b1, (i == fw - 1)});
      end
    end
    if (iv) begin
      for (int i = 0; i < iw; i++) begin
        exp_addr_q.push_back(ADDR_W'((ib + i) % 4096));
        exp_q.push_back('{mem[(ib + i) % 4096], 1'b0, (i == iw - 1)});
      end
    end
  endtask

  // run until every requested finish flag is up; rmode 0 ready=1, 1 = 1,0,0,.. , 2 random
  task automatic wait_fin(input int budget, input int rmode, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      case (rmode)
        0:       strm_ready = 1'b1;
        1:       strm_ready = (c % 3 == 0);
        default: strm_ready = 1'($urandom_range(0, 1));
      endcase
      if ((!cur_fv || stream_filter_finish) && (!cur_iv || stream_input_finish)) begin
        ok = 1; break;
      end
    end
    strm_ready = 1'b1;
  endtask

  task automatic release_req();
    req_filter_valid = 0; req_input_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0; strm_ready = 0;
    req_filter_valid = 0; req_input_valid = 0; req_filter_k = 0; req_conv_layer = 0;
    cfg_filter_base = 0; cfg_filter_words = 0; cfg_input_base = 0; cfg_input_words = 0;
    #3;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs got=%h exp=0", outs); end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy, strm_valid, mem_rd_en} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got=%b exp=000", {busy, strm_valid, mem_rd_en});
    end
  endtask

  task automatic test_filter_only();
    bit ok;
    strm_ready = 1;
    drive_req(1, 2, 5, 0, 'h100, 4, 'h300, 7);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, mem_rd_en, strm_valid} !== 3'b110) begin
      errors++; $display("FAIL filt_enter got=%b exp=110", {busy, mem_rd_en, strm_valid});
    end
    @(negedge clk);
    checks++;
    if (strm_valid !== 1'b0) begin errors++; $display("FAIL filt_lat1 got=%b exp=0", strm_valid); end
    @(negedge clk);
    checks++;
    if (strm_valid !== 1'b1) begin errors++; $display("FAIL filt_lat2 got=%b exp=1", strm_valid); end
    wait_fin(50, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL filt_timeout got=0 exp=1"); end
    checks++;
    if (first_bad_addr() != -1) begin
      errors++; $display("FAIL filt_addr idx=%0d got_n=%0d exp_n=%0d", first_bad_addr(), got_addr_q.size(), exp_addr_q.size());
    end
    checks++;
    if (first_bad_beat() != -1) begin
      errors++; $display("FAIL filt_beats idx=%0d got_n=%0d exp_n=%0d", first_bad_beat(), got_q.size(), exp_q.size());
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({stream_filter_finish, stream_input_finish, strm_layer} !== {2'b10, cur_layer}) begin
      errors++; $display("FAIL filt_hold got=%b exp=%b", {stream_filter_finish, stream_input_finish, strm_layer}, {2'b10, cur_layer});
    end
    req_filter_valid = 0;
    @(negedge clk);
    checks++;
    if ({stream_filter_finish, busy} !== 2'b11) begin
      errors++; $display("FAIL filt_predrop got=%b exp=11", {stream_filter_finish, busy});
    end
    @(negedge clk);
    checks++;
    if ({stream_filter_finish, stream_input_finish, busy} !== 3'b000) begin
      errors++; $display("FAIL filt_clear got=%b exp=000", {stream_filter_finish, stream_input_finish, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both();
    bit ok;
    strm_ready = 1;
    drive_req(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, $urandom_range(0, 4095), 3, 'h200, 5);
    wait_fin(80, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL both_timeout got=0 exp=1"); end
    checks++;
    if (first_bad_beat() != -1) begin
      errors++; $display("FAIL both_beats idx=%0d got_n=%0d exp_n=%0d", first_bad_beat(), got_q.size(), exp_q.size());
    end
    checks++;
    if (first_bad_addr() != -1) begin
      errors++; $display("FAIL both_addr idx=%0d got_n=%0d exp_n=%0d", first_bad_addr(), got_addr_q.size(), exp_addr_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if ({stream_filter_finish, stream_input_finish} !== 2'b11) begin
      errors++; $display("FAIL both_fin got=%b exp=11", {stream_filter_finish, stream_input_finish});
    end
    req_filter_valid = 0; req_input_valid = 0;
    @(posedge clk); #1;
    checks++;
    if ({stream_filter_finish, stream_input_finish, busy} !== 3'b000) begin
      errors++; $display("FAIL both_clear got=%b exp=000", {stream_filter_finish, stream_input_finish, busy});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    drive_req(0, 0, 1, 1, 0, 0, $urandom_range(0, 4095), 6);
    wait_fin(200, 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got=0 exp=1"); end
    checks++;
    if (first_bad_beat() != -1) begin
      errors++; $display("FAIL bp_beats idx=%0d got_n=%0d exp_n=%0d", first_bad_beat(), got_q.size(), exp_q.size());
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
    release_req();
  endtask

  task automatic test_zero_len();
    strm_ready = 1;
    drive_req(1, 3, 2, 0, $urandom_range(0, 4095), 0, 0, 4);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, stream_filter_finish} !== 2'b10) begin
      errors++; $display("FAIL zero_enter got=%b exp=10", {busy, stream_filter_finish});
    end
    @(negedge clk);
    checks++;
    if ({stream_filter_finish, stream_input_finish} !== 2'b10) begin
      errors++; $display("FAIL zero_fin got=%b exp=10", {stream_filter_finish, stream_input_finish});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() + got_addr_q.size() != 0 || strm_valid !== 1'b0) begin
      errors++; $display("FAIL zero_beats got=%0d exp=0", got_q.size() + got_addr_q.size());
    end
    @(posedge clk); #1;
    release_req();
  endtask

  task automatic test_wrap();
    bit ok;
    drive_req(1, 0, 6, 0, 'hFFE, 4, 0, 0);
    wait_fin(50, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout got=0 exp=1"); end
    checks++;
    if (got_addr_q.size() != 4 || got_addr_q[1] !== 12'hFFF || got_addr_q[2] !== 12'h000 || first_bad_addr() != -1) begin
      errors++; $display("FAIL wrap_addr idx=%0d got_n=%0d exp_n=4", first_bad_addr(), got_addr_q.size());
    end
    checks++;
    if (first_bad_beat() != -1) begin
      errors++; $display("FAIL wrap_beats idx=%0d got_n=%0d exp_n=%0d", first_bad_beat(), got_q.size(), exp_q.size());
    end
    release_req();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int ib;
    ib = $urandom_range(0, 4095);
    strm_ready = 1;
    drive_req(0, 0, 4, 1, 0, 0, ib, 8);
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 2) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_timeout got=%0d exp=2", got_q.size()); end
    #1 rst = 0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rmid_outs got=%h exp=0", outs); end
    req_input_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy, strm_valid} !== 2'b00) begin
      errors++; $display("FAIL rmid_idle got=%b exp=00", {busy, strm_valid});
    end
    drive_req(0, 0, 4, 1, 0, 0, ib, 8);
    wait_fin(60, 0, ok);
    checks++;
    if (!ok || first_bad_addr() != -1 || first_bad_beat() != -1) begin
      errors++; $display("FAIL rmid_restart ok=%0d addr_idx=%0d beat_idx=%0d exp=-1", ok, first_bad_addr(), first_bad_beat());
    end
    release_req();
  endtask

  task automatic test_random();
    bit ok, fv, iv;
    for (int n = 0; n < 8; n++) begin
      fv = 1'($urandom_range(0, 1));
      iv = fv ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_req(fv, $urandom_range(0, 3), $urandom_range(0, 7), iv, $urandom_range(0, 4095),
                $urandom_range(0, 6), $urandom_range(0, 4095), $urandom_range(0, 6));
      wait_fin(300, 2, ok);
      checks++;
      if (!ok || first_bad_beat() != -1 || first_bad_addr() != -1) begin
        errors++; $display("FAIL rand%0d ok=%0d beat_idx=%0d addr_idx=%0d exp=-1", n, ok, first_bad_beat(), first_bad_addr());
      end
      checks++;
      if (stab_err != 0 || max_out > 2) begin
        errors++; $display("FAIL rand%0d_flow stab=%0d max_out=%0d exp=0,<=2", n, stab_err, max_out);
      end
      @(posedge clk); #1;
      checks++;
      if ({stream_filter_finish, stream_input_finish, strm_layer} !== {fv, iv, cur_layer}) begin
        errors++; $display("FAIL rand%0d_fin got=%b exp=%b", n, {stream_filter_finish, stream_input_finish, strm_layer}, {fv, iv, cur_layer});
      end
      release_req();
    end
  endtask

  initial begin
    checks = 0; errors = 0; prev_stall = 0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    test_reset();
    test_filter_only();
    test_both();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
